fb_access_arbiter: RTL and testbench
====================================

// Module: fb_access_arbiter
// PURPOSE
//  Shares one single-port pixel framebuffer RAM between display scan-out and a draw-engine writer.
//  Scan-out reads have fixed-slot priority; writer traffic is buffered in a small FIFO and drained
//  into free slots. Framebuffer is half resolution (each fb pixel shown 2x2), so every odd scan_x
//  cycle and all blanking cycles are free for writes.
//  Sits between the pixel-timing generator (supplies scan_x/scan_y) and the framebuffer RAM.
// PARAMETERS
//  WIDTH       640   active pixels per line
//  HEIGHT      480   active lines per frame
//  COOR_WIDTH  11    width of scan_x / scan_y
//  FB_W        320   framebuffer width  (= WIDTH/2)
//  FB_H        240   framebuffer height (= HEIGHT/2)
//  FB_ADDR_W   17    framebuffer address width (>= clog2(FB_W*FB_H))
//  PIX_W       24    pixel width {r[7:0],g[7:0],b[7:0]}
//  FIFO_DEPTH  4     write FIFO entries, power of 2, >= 2
// PORTS
//  pixclk     in   1           pixel clock; all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  scan_x     in   COOR_WIDTH  current pixel column from timing generator
//  scan_y     in   COOR_WIDTH  current line from timing generator
//  wr_valid   in   1           writer request valid
//  wr_ready   out  1           FIFO can accept; transfer on wr_valid & wr_ready
//  wr_addr    in   FB_ADDR_W   writer fb address (linear, y*FB_W+x)
//  wr_data    in   PIX_W       writer pixel
//  wr_err     out  1           sticky: an out-of-range write was dropped
//  mem_en     out  1           RAM enable
//  mem_we     out  1           RAM write enable (mem_en=1 required)
//  mem_addr   out  FB_ADDR_W   RAM address
//  mem_wdata  out  PIX_W       RAM write data
//  mem_rdata  in   PIX_W       RAM read data, valid 1 cycle after read
//  pix_out    out  PIX_W       display pixel, 2 cycles after its scan_x/scan_y
//  pix_valid  out  1           pix_out belongs to the active area (2-cycle delayed)
// BEHAVIOUR
//  - Reset: mem_en/mem_we/pix_valid/wr_err = 0, mem_addr/mem_wdata/pix_out = 0, FIFO empty,
//    wr_ready = 0 while rst=1, 1 on first cycle after.
//  - Slot decode per cycle: RD_SLOT iff scan_x<WIDTH && scan_y<HEIGHT && scan_x[0]==0; else WR_SLOT.
//  - RD_SLOT (registered, next edge): mem_en=1, mem_we=0,
//    mem_addr = (scan_y>>1)*FB_W + (scan_x>>1), computed at FB_ADDR_W, no wrap.
//  - WR_SLOT: if FIFO non-empty, pop head -> mem_en=1, mem_we=1, mem_addr/mem_wdata=entry;
//    else mem_en=0, mem_we=0.
//  - Read path: rdata captured in the cycle after the read, held in pix_out for 2 cycles
//    (covers even and odd columns). Total latency scan_x -> pix_out = 2 cycles.
//    Outside active area pix_out = 0, pix_valid = 0.
//  - Writer: wr_ready = !fifo_full && !rst (combinational).
//    wr_addr >= FB_W*FB_H is accepted (handshake completes), discarded, and sets wr_err
//    (cleared only by rst).
//  - Simultaneous push+pop: count unchanged, both act. Push when full impossible (ready=0).
//  - Writes are never reordered. A read and a write to the same address in adjacent slots follow
//    slot order; no forwarding.
//  - Reset mid-operation: FIFO flushed (pending writes lost), mem_en=0 after the edge,
//    pix_out=0 until the next valid read returns.
//  - Drain rate: >= 1 write per 2 cycles in active area, 1 per cycle in blanking.
// STRUCTURE
//  - Shared include parameters.v: WIDTH, HEIGHT, COOR_WIDTH, blanking constants, FB_W/FB_H,
//    FB_ADDR_W, PIX_W.
//  - Sub-module fb_wr_fifo: sync FIFO {addr,data}, push/pop/full/empty, pointer+1 bit full
//    detect, synchronous rst.
//  - Top: slot decode, address multiply-add (shift-add, FB_W constant), memory mux,
//    2-stage pixel pipeline.
// TESTING
//  1. Reset: rst=1 for 3 cycles with wr_valid=1 -> wr_ready=0, mem_en=0, FIFO empty.
//     Release -> wr_ready=1 next cycle.
//  2. Scan read: scan=(6,4) -> next edge mem_en=1, we=0, addr=2*320+3=643.
//     RAM returns 0xA1B2C3 -> pix_out=0xA1B2C3 at cycles +2,+3.
//  3. Slot sharing: writer streams 8 writes from scan_x=0, active line ->
//     mem_we only on odd-x cycles, 8 writes in order. No read slot lost.
//  4. Backpressure: 6 writes in active area, FIFO_DEPTH=4 -> wr_ready drops after 4 pushes
//     net of drains, recovers. All 6 reach RAM in order.
//  5. Out-of-range: wr_addr=76800 -> handshake completes, no mem_we for it, wr_err=1 until rst.
//  6. Blanking + reset mid-drain: 3 writes queued at scan_x=WIDTH -> drain on consecutive cycles.
//     rst after 1st -> 2nd/3rd never written.

Source files
------------

// File: rtl/fb_access_arbiter_pkg.sv
// Shared constants, types and the read-address helper for the framebuffer access arbiter.
package fb_access_arbiter_pkg;

    localparam int WIDTH      = 640;
    localparam int HEIGHT     = 480;
    localparam int COOR_WIDTH = 11;
    localparam int FB_W       = WIDTH / 2;
    localparam int FB_H       = HEIGHT / 2;
    localparam int FB_ADDR_W  = 17;
    localparam int PIX_W      = 24;
    localparam int FB_PIXELS  = FB_W * FB_H;

    typedef logic [COOR_WIDTH-1:0] coord_t;
    typedef logic [FB_ADDR_W-1:0]  fb_addr_t;
    typedef logic [PIX_W-1:0]      pix_t;

    typedef enum logic {
        RD_SLOT,
        WR_SLOT
    } slot_e;

    typedef struct packed {
        fb_addr_t addr;
        pix_t     data;
    } wr_req_t;

    typedef struct packed {
        logic     en;
        logic     we;
        fb_addr_t addr;
        pix_t     wdata;
    } mem_req_t;

    // (y>>1)*FB_W + (x>>1) as a constant shift-add; one adder per set bit of FB_W.
    function automatic fb_addr_t fb_rd_addr(input coord_t x, input coord_t y);
        fb_addr_t col;
        fb_addr_t row;
        fb_addr_t acc;
        col = fb_addr_t'(x >> 1);
        row = fb_addr_t'(y >> 1);
        acc = col;
        for (int b = 0; b < FB_ADDR_W; b++) begin
            if (FB_W[b]) acc = acc + (row << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_access_arbiter_wr_fifo.sv
// Synchronous show-ahead FIFO for pending framebuffer writes; extra pointer bit separates full from empty.
module fb_access_arbiter_wr_fifo
    import fb_access_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  wr_req_t i_req,
    input  logic    i_pop,
    output wr_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    wr_req_t     r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst) r_mem[r_wptr[AW-1:0]] <= i_req;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: even active columns read for scan-out, every other cycle
// drains the writer FIFO. Display pixels appear two cycles after their scan coordinate.
module fb_access_arbiter
    import fb_access_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_pixclk,
    input  logic                  i_rst,
    input  logic [COOR_WIDTH-1:0] i_scan_x,
    input  logic [COOR_WIDTH-1:0] i_scan_y,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [FB_ADDR_W-1:0]  i_wr_addr,
    input  logic [PIX_W-1:0]      i_wr_data,
    output logic                  o_wr_err,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [FB_ADDR_W-1:0]  o_mem_addr,
    output logic [PIX_W-1:0]      o_mem_wdata,
    input  logic [PIX_W-1:0]      i_mem_rdata,
    output logic [PIX_W-1:0]      o_pix_out,
    output logic                  o_pix_valid
);

    localparam coord_t   ACT_W    = coord_t'(WIDTH);
    localparam coord_t   ACT_H    = coord_t'(HEIGHT);
    localparam fb_addr_t FB_LIMIT = fb_addr_t'(FB_PIXELS);

    logic     w_active;
    slot_e    w_slot;
    fb_addr_t w_rd_addr;
    logic     w_fire;
    logic     w_in_range;
    logic     w_push;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    wr_req_t  w_req;
    wr_req_t  w_head;
    mem_req_t w_mem_nxt;
    mem_req_t r_mem;
    logic     r_wr_err;
    logic [2:1] r_vld_pipe;
    logic [2:1] r_rd_pipe;
    pix_t     r_pix_hold;

    assign w_active  = (i_scan_x < ACT_W) && (i_scan_y < ACT_H);
    assign w_slot    = (w_active && !i_scan_x[0]) ? RD_SLOT : WR_SLOT;
    assign w_rd_addr = fb_rd_addr(i_scan_x, i_scan_y);

    // Out-of-range writes still complete the handshake so the writer never stalls on them.
    assign o_wr_ready = !w_full && !i_rst;
    assign w_fire     = i_wr_valid && o_wr_ready;
    assign w_in_range = (i_wr_addr < FB_LIMIT);
    assign w_push     = w_fire && w_in_range;
    assign w_pop      = (w_slot == WR_SLOT) && !w_empty;
    assign w_req      = '{addr: i_wr_addr, data: i_wr_data};

    fb_access_arbiter_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_pixclk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_req   (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_mem_nxt       = r_mem;
        w_mem_nxt.en    = 1'b0;
        w_mem_nxt.we    = 1'b0;
        if (w_slot == RD_SLOT) begin
            w_mem_nxt.en   = 1'b1;
            w_mem_nxt.addr = w_rd_addr;
        end else if (!w_empty) begin
            w_mem_nxt.en    = 1'b1;
            w_mem_nxt.we    = 1'b1;
            w_mem_nxt.addr  = w_head.addr;
            w_mem_nxt.wdata = w_head.data;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            r_mem    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_mem <= w_mem_nxt;
            if (w_fire && !w_in_range) r_wr_err <= 1'b1;
        end
    end

    // Stage 2 of the read pipe is the cycle the RAM data is on i_mem_rdata; the odd column reuses it.
    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_rd_pipe  <= '0;
            r_pix_hold <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], w_active};
            r_rd_pipe  <= {r_rd_pipe[1], (w_slot == RD_SLOT)};
            if (r_rd_pipe[2]) r_pix_hold <= i_mem_rdata;
        end
    end

    assign o_mem_en    = r_mem.en;
    assign o_mem_we    = r_mem.we;
    assign o_mem_addr  = r_mem.addr;
    assign o_mem_wdata = r_mem.wdata;
    assign o_wr_err    = r_wr_err;
    assign o_pix_valid = r_vld_pipe[2];
    assign o_pix_out   = !r_vld_pipe[2] ? '0 :
                         r_rd_pipe[2]   ? i_mem_rdata : r_pix_hold;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a one-cycle-latency RAM model and a write log.
module tb_fb_access_arbiter;
    import fb_access_arbiter_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [COOR_WIDTH-1:0] sx, sy;
    logic                  wr_valid, wr_ready, wr_err;
    logic [FB_ADDR_W-1:0]  wr_addr, mem_addr;
    logic [PIX_W-1:0]      wr_data, mem_wdata, mem_rdata, pix_out;
    logic                  mem_en, mem_we, pix_valid;

    int errors = 0;
    int checks = 0;
    int nreads;
    logic rdy_hist [0:31];
    logic [FB_ADDR_W-1:0] wlog_a [$];
    logic [PIX_W-1:0]     wlog_d [$];

    fb_access_arbiter #(.FIFO_DEPTH(4)) dut (
        .i_pixclk    (clk),
        .i_rst       (rst),
        .i_scan_x    (sx),
        .i_scan_y    (sy),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_err    (wr_err),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_pix_out   (pix_out),
        .o_pix_valid (pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= (mem_addr == 17'd643) ? 24'hA1B2C3 : {7'd0, mem_addr};
        if (mem_en && mem_we) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    // One active line from x=0; writer offers nwr writes starting at column wr_x0.
    task automatic stream(input int y, input int wr_x0, input int nwr, input int ncyc,
                          input int abase, output int nrd);
        int  k = 0;
        logic hs;
        nrd = 0;
        for (int x = 0; x < ncyc; x++) begin
            sx       = COOR_WIDTH'(x);
            sy       = COOR_WIDTH'(y);
            wr_valid = (x >= wr_x0) && (k < nwr);
            wr_addr  = FB_ADDR_W'(abase + k);
            wr_data  = PIX_W'(24'hD00000 + k);
            rdy_hist[x] = wr_ready;
            hs = wr_valid && wr_ready;
            step();
            if (hs) k++;
            if (mem_en && !mem_we) nrd++;
            if (mem_we) chk("we_in_odd_slot", 32'(x % 2), 32'd1);
            if (x % 2 == 0) chk("rd_slot_issue", 32'({mem_en, mem_we}), 32'd2);
        end
        wr_valid = 1'b0;
        sx = 11'd700;
    endtask

    initial begin
        rst = 1'b1; sx = 11'd700; sy = 11'd0;
        wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 24'h123456;

        // reset with writer pushing
        repeat (3) step();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_out", 32'(pix_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0; wr_valid = 1'b0;
        step();
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        chk("rel_fifo_empty", 32'(mem_en), 32'd0);

        // scan read at (6,4)
        sx = 11'd6; sy = 11'd4;
        step();
        chk("rd_en", 32'(mem_en), 32'd1);
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'd643);
        sx = 11'd7;
        step();
        chk("odd_slot_idle", 32'(mem_en), 32'd0);
        chk("pix_even", 32'(pix_out), 32'hA1B2C3);
        chk("pix_even_vld", 32'(pix_valid), 32'd1);
        sx = 11'd700;
        step();
        chk("pix_odd", 32'(pix_out), 32'hA1B2C3);
        chk("pix_odd_vld", 32'(pix_valid), 32'd1);
        step();
        chk("pix_blank", 32'(pix_out), 32'd0);
        chk("pix_blank_vld", 32'(pix_valid), 32'd0);

        // slot sharing: 8 writes streamed from x=0
        clear_log();
        stream(10, 0, 8, 24, 100, nreads);
        chk("t3_reads", 32'(nreads), 32'd12);
        chk("t3_full_stall", 32'(rdy_hist[7]), 32'd0);
        chk("t3_nwrites", 32'(wlog_a.size()), 32'd8);
        for (int k = 0; k < wlog_a.size(); k++) begin
            chk("t3_addr", 32'(wlog_a[k]), 32'(100 + k));
            chk("t3_data", 32'(wlog_d[k]), 32'(24'hD00000 + k));
        end

        // backpressure: 6 writes from x=1
        clear_log();
        stream(20, 1, 6, 20, 200, nreads);
        chk("t4_reads", 32'(nreads), 32'd10);
        chk("t4_ready_x6", 32'(rdy_hist[6]), 32'd1);
        chk("t4_ready_drop", 32'(rdy_hist[7]), 32'd0);
        chk("t4_ready_back", 32'(rdy_hist[8]), 32'd1);
        chk("t4_nwrites", 32'(wlog_a.size()), 32'd6);
        for (int k = 0; k < wlog_a.size(); k++)
            chk("t4_addr", 32'(wlog_a[k]), 32'(200 + k));

        // out-of-range write, then last legal address
        clear_log();
        sx = 11'd700; sy = 11'd0;
        wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 24'h000001;
        chk("t5_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        chk("t5_err_set", 32'(wr_err), 32'd1);
        step();
        chk("t5_dropped", 32'(mem_en), 32'd0);
        wr_valid = 1'b1; wr_addr = 17'd76799; wr_data = 24'h777777;
        step();
        wr_valid = 1'b0;
        step();
        chk("t5_edge_we", 32'(mem_we), 32'd1);
        chk("t5_edge_addr", 32'(mem_addr), 32'd76799);
        chk("t5_edge_data", 32'(mem_wdata), 32'h777777);
        step();
        chk("t5_err_sticky", 32'(wr_err), 32'd1);
        chk("t5_nwrites", 32'(wlog_a.size()), 32'd1);

        // blanking drain on consecutive cycles
        clear_log();
        for (int i = 0; i < 4; i++) begin
            sx = COOR_WIDTH'(640 + i);
            wr_valid = (i < 3);
            wr_addr  = FB_ADDR_W'(300 + i);
            wr_data  = PIX_W'(24'hE00000 + i);
            step();
            if (i > 0) begin
                chk("t6_drain_we", 32'(mem_we), 32'd1);
                chk("t6_drain_addr", 32'(mem_addr), 32'(300 + i - 1));
            end
        end
        wr_valid = 1'b0;
        step();
        chk("t6_drain_done", 32'(mem_en), 32'd0);

        // reset in the middle of a drain
        clear_log();
        sx = 11'd650; wr_valid = 1'b1; wr_addr = 17'd400; wr_data = 24'hF00000;
        step();
        sx = 11'd651; wr_addr = 17'd401; wr_data = 24'hF00001;
        step();
        chk("t6_first_we", 32'(mem_we), 32'd1);
        chk("t6_first_addr", 32'(mem_addr), 32'd400);
        chk("t6_err_before_rst", 32'(wr_err), 32'd1);
        sx = 11'd652; wr_addr = 17'd402; wr_data = 24'hF00002; rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", 32'(wr_ready), 32'd0);
        step();
        chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
        chk("t6_rst_err_clr", 32'(wr_err), 32'd0);
        chk("t6_rst_pix", 32'(pix_out), 32'd0);
        rst = 1'b0; wr_valid = 1'b0;
        repeat (4) step();
        chk("t6_flushed", 32'(wlog_a.size()), 32'd1);
        chk("t6_only_first", 32'(wlog_a[0]), 32'd400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
